// File: rtl/ser_scheduler_pkg.sv
// Shared constants for the serializer scheduler: FSM encodings, byte geometry
// and the pointer-advance helper used by the arbiter bookkeeping.
package ser_scheduler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam int         BYTE_W     = 8;
  localparam logic [2:0] SHIFT_LAST = 3'd7;

  // Next round-robin start position after a grant to requester v.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/ser_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at ptr, wraps past the
// top requester back to 0, and the first asserted request wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  // slot_idx[k] is the requester examined k-th in priority order.
  logic [ID_W-1:0]  slot_idx [N_REQ];
  logic [N_REQ-1:0] slot_hit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign slot_idx[gi] = ID_W'((int'(ptr) + gi) % N_REQ);
    assign slot_hit[gi] = req[slot_idx[gi]];
  end

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (slot_hit[k]) begin
        id  = slot_idx[k];
        any = 1'b1;
      end
    end
    gnt[id] = any;
  end

endmodule

// File: rtl/ser_scheduler.sv
// Round-robin scheduler feeding one LSB-first byte serializer: grants a byte,
// pulses the load strobe, then tracks the 8 shift cycles and the output strobes.
module ser_scheduler
  import ser_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clock_ser,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]       ser_data,
  output logic                    ser_enable,
  output logic                    bit_valid,
  output logic                    bit_last,
  output logic [ID_W-1:0]         bit_owner,
  output logic                    busy
);

  logic [1:0]        state_reg;
  logic [2:0]        cnt_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   owner_reg;
  logic [BYTE_W-1:0] ser_data_reg;
  logic              ser_enable_reg;
  logic              bit_valid_reg;
  logic              bit_last_reg;
  logic [ID_W-1:0]   bit_owner_reg;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              any_req;
  logic              accept_window;
  logic              accept;
  logic [BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .gnt (gnt),
    .id  (gnt_id),
    .any (any_req)
  );

  // A new byte can only be taken while idle or on the final shift cycle,
  // which is what gives the 9-cycle back-to-back period.
  assign accept_window = (state_reg == ST_IDLE) ||
                         ((state_reg == ST_SHIFT) && (cnt_reg == SHIFT_LAST));
  assign accept        = !reset && accept_window && any_req;
  assign req_ready     = accept ? gnt : '0;

  always_ff @(posedge clock_ser) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      rr_ptr_reg     <= '0;
      owner_reg      <= '0;
      ser_data_reg   <= '0;
      ser_enable_reg <= 1'b0;
      bit_valid_reg  <= 1'b0;
      bit_last_reg   <= 1'b0;
      bit_owner_reg  <= '0;
    end else begin
      ser_enable_reg <= accept;
      // The serializer output changes on the edge closing each shift cycle,
      // so the strobes are the shift-state flags delayed by one register.
      bit_valid_reg  <= (state_reg == ST_SHIFT);
      bit_last_reg   <= (state_reg == ST_SHIFT) && (cnt_reg == SHIFT_LAST);
      if (state_reg == ST_SHIFT) begin
        bit_owner_reg <= owner_reg;
      end

      if (accept) begin
        ser_data_reg <= req_bytes[gnt_id];
        owner_reg    <= gnt_id;
        rr_ptr_reg   <= ID_W'(wrap_inc(int'(gnt_id), N_REQ));
      end

      case (state_reg)
        ST_IDLE: begin
          if (accept) state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          state_reg <= ST_SHIFT;
          cnt_reg   <= '0;
        end
        ST_SHIFT: begin
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == SHIFT_LAST) begin
            state_reg <= accept ? ST_LOAD : ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ser_data   = ser_data_reg;
  assign ser_enable = ser_enable_reg;
  assign bit_valid  = bit_valid_reg;
  assign bit_last   = bit_last_reg;
  assign bit_owner  = bit_owner_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule
